// File: rtl/izhikevich_array_core.sv
// Time-multiplexed Izhikevich neuron engine: one shared sign-magnitude multiplier plus a
// small adder chain walk every neuron through a 10-cycle forward-Euler update per step.
module izhikevich_array_core #(
  parameter int N           = 32,
  parameter int Q           = 16,
  parameter int NUM_NEURONS = 4,
  parameter int AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter logic [N-1:0] V_INIT = 32'h8041_0000,
  parameter logic [N-1:0] W_INIT = 32'h800D_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_start,
  input  logic [N-1:0]           a,
  input  logic [N-1:0]           b,
  input  logic [N-1:0]           c,
  input  logic [N-1:0]           d,
  input  logic [N-1:0]           dt,
  input  logic [N-1:0]           v_th,
  output logic [AW-1:0]          i_addr,
  input  logic [N-1:0]           i_data,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [N-1:0]           wr_v,
  input  logic [N-1:0]           wr_w,
  input  logic [AW-1:0]          rd_addr,
  output logic [N-1:0]           rd_v,
  output logic [N-1:0]           rd_w,
  output logic                   busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] spikes
);

  localparam logic [N-1:0] K_004 = 32'h0000_0A3D;
  localparam logic [N-1:0] K_5   = 32'h0005_0000;
  localparam logic [N-1:0] K_140 = 32'h008C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_MVV, S_MK, S_M5, S_DV, S_MBV, S_DW, S_IV, S_IW, S_WB
  } state_t;

  // Magnitude product truncated by Q, saturating; a zero result is always +0.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-3:0] prod;
    logic [N-2:0]   mag;
    prod = ({{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, y[N-2:0]}) >> Q;
    if (|prod[2*N-3:N-1]) mag = '1;
    else                  mag = prod[N-2:0];
    return {(x[N-1] ^ y[N-1]) & (|mag), mag};
  endfunction

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    sum = '0;
    if (x[N-1] == y[N-1]) begin
      sum = {1'b0, x[N-2:0]} + {1'b0, y[N-2:0]};
      mag = sum[N-1] ? '1 : sum[N-2:0];
      sgn = x[N-1];
    end else if (x[N-2:0] >= y[N-2:0]) begin
      mag = x[N-2:0] - y[N-2:0];
      sgn = x[N-1];
    end else begin
      mag = y[N-2:0] - x[N-2:0];
      sgn = y[N-1];
    end
    return {sgn & (|mag), mag};
  endfunction

  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] x);
    return {~x[N-1], x[N-2:0]};
  endfunction

  function automatic logic sm_ge(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [N:0] xs;
    logic signed [N:0] ys;
    xs = x[N-1] ? -$signed({2'b00, x[N-2:0]}) : $signed({2'b00, x[N-2:0]});
    ys = y[N-1] ? -$signed({2'b00, y[N-2:0]}) : $signed({2'b00, y[N-2:0]});
    return xs >= ys;
  endfunction

  state_t                 state_q, state_d;
  logic [AW-1:0]          n_q, n_d;
  logic                   done_q, done_d;
  logic                   start_acc, wb_en, last_n, spike_hit, host_wr;
  logic [NUM_NEURONS-1:0] spikes_q;
  logic [N-1:0]           v_mem_q [NUM_NEURONS];
  logic [N-1:0]           w_mem_q [NUM_NEURONS];

  logic [N-1:0] v_q, w_q, i_q, t_q, u_q, dv_q, dw_q, vn_q, wn_q;

  logic [N-1:0] mul_x, mul_y, mul_r;
  logic [N-1:0] add0_x, add0_y, add0_r, add1_r;
  logic [N-1:0] add2_x, add2_y, add2_r, add3_r;

  assign last_n    = (n_q == AW'(NUM_NEURONS - 1));
  assign spike_hit = sm_ge(vn_q, v_th);
  assign host_wr   = wr_en && (state_q == S_IDLE) && !step_start &&
                     (int'(wr_addr) < NUM_NEURONS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d   = S_FETCH;
          n_d       = '0;
          start_acc = 1'b1;
        end
      end
      S_FETCH: state_d = S_MVV;
      S_MVV:   state_d = S_MK;
      S_MK:    state_d = S_M5;
      S_M5:    state_d = S_DV;
      S_DV:    state_d = S_MBV;
      S_MBV:   state_d = S_DW;
      S_DW:    state_d = S_IV;
      S_IV:    state_d = S_IW;
      S_IW:    state_d = S_WB;
      S_WB: begin
        wb_en = 1'b1;
        if (last_n) begin
          state_d = S_IDLE;
          n_d     = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          n_d     = n_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand muxes are split so no process both feeds and consumes the multiplier.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      S_MVV: begin mul_x = v_q;   mul_y = v_q;    end
      S_MK:  begin mul_x = K_004; mul_y = t_q;    end
      S_M5:  begin mul_x = K_5;   mul_y = v_q;    end
      S_MBV: begin mul_x = b;     mul_y = v_q;    end
      S_DW:  begin mul_x = a;     mul_y = add0_r; end
      S_IV:  begin mul_x = dt;    mul_y = dv_q;   end
      S_IW:  begin mul_x = dt;    mul_y = dw_q;   end
      default: ;
    endcase
  end

  always_comb begin
    add0_x = '0;
    add0_y = '0;
    case (state_q)
      S_DV: begin add0_x = t_q;  add0_y = u_q;         end
      S_DW: begin add0_x = t_q;  add0_y = sm_neg(w_q); end
      S_WB: begin add0_x = wn_q; add0_y = d;           end
      default: ;
    endcase
  end

  always_comb begin
    add2_x = '0;
    add2_y = '0;
    case (state_q)
      S_DV: begin add2_x = i_q; add2_y = sm_neg(w_q); end
      S_IV: begin add2_x = v_q; add2_y = mul_r;       end
      S_IW: begin add2_x = w_q; add2_y = mul_r;       end
      default: ;
    endcase
  end

  assign mul_r  = sm_mul(mul_x, mul_y);
  assign add0_r = sm_add(add0_x, add0_y);
  assign add1_r = sm_add(add0_r, K_140);
  assign add2_r = sm_add(add2_x, add2_y);
  assign add3_r = sm_add(add1_r, add2_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q  <= '0;
      w_q  <= '0;
      i_q  <= '0;
      t_q  <= '0;
      u_q  <= '0;
      dv_q <= '0;
      dw_q <= '0;
      vn_q <= '0;
      wn_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          v_q <= v_mem_q[n_q];
          w_q <= w_mem_q[n_q];
          i_q <= i_data;
        end
        S_MVV, S_MK, S_MBV: t_q <= mul_r;
        S_M5: u_q  <= mul_r;
        S_DV: dv_q <= add3_r;
        S_DW: dw_q <= mul_r;
        S_IV: vn_q <= add2_r;
        S_IW: wn_q <= add2_r;
        default: ;
      endcase
    end
  end

  // A spiking neuron takes c for v and wn + d (from adder 0 in WB) for w.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem_q[k] <= V_INIT;
        w_mem_q[k] <= W_INIT;
      end
    end else if (wb_en) begin
      v_mem_q[n_q] <= spike_hit ? c : vn_q;
      w_mem_q[n_q] <= spike_hit ? add0_r : wn_q;
    end else if (host_wr) begin
      v_mem_q[wr_addr] <= wr_v;
      w_mem_q[wr_addr] <= wr_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_acc) spikes_q <= '0;
    else if (wb_en && spike_hit) spikes_q[n_q] <= 1'b1;
  end

  assign rd_v      = (int'(rd_addr) < NUM_NEURONS) ? v_mem_q[rd_addr] : '0;
  assign rd_w      = (int'(rd_addr) < NUM_NEURONS) ? w_mem_q[rd_addr] : '0;
  assign i_addr    = n_q;
  assign busy      = (state_q != S_IDLE);
  assign step_done = done_q;
  assign spikes    = spikes_q;

endmodule

// File: doc/izhikevich_array_core.md
Name: izhikevich_array_core

Overview:
- Time-multiplexed Izhikevich neuron engine for NUM_NEURONS neurons sharing one fixed-point multiplier and one adder chain.
- On each step request it applies one forward-Euler update per neuron: dv = 0.04v^2 + 5v + 140 - w + i, dw = a(bv - w), v += dt*dv, w += dt*dw.
- It then does threshold/reset and builds a spike vector.
- Sits between the synaptic-current source, which supplies i per neuron, and spike routing.

Parameters:
N, 32, word width; sign-magnitude, MSB = sign
Q, 16, fractional bits
NUM_NEURONS, 4, neurons in state memory (>=1)
AW, $clog2(NUM_NEURONS) min 1, neuron index width
V_INIT, 0x8041_0000 (-65.0), v reset value
W_INIT, 0x800D_0000 (-13.0), w reset value

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
step_start  in  1  request one update of all neurons
a, b, c, d  in  N each  model parameters, shared by all neurons
dt  in  N  Euler step
v_th  in  N  spike threshold (nominal 30.0)
i_addr  out  AW  neuron whose input current is requested
i_data  in  N  input current for i_addr; combinational, sampled in FETCH
wr_en  in  1  host write of one neuron state
wr_addr  in  AW  neuron to write
wr_v, wr_w  in  N each  values to write
rd_addr  in  AW  read index
rd_v, rd_w  out  N each  combinational read of the state array
busy  out  1  step in progress
step_done  out  1  one-cycle pulse at step completion
spikes  out  NUM_NEURONS  spike flags of the last step

Behaviour:
- Reset:
  - v[*] = V_INIT, w[*] = W_INIT; busy = 0, step_done = 0, spikes = 0, i_addr = 0.
  - FSM goes to IDLE.
  - Reset during a step aborts it; no partial writeback survives.
- Arithmetic (all ops):
  - mult: sign = XOR of signs; magnitude = (|x|*|y|) >> Q, truncated.
  - add: sign-magnitude add/subtract.
  - Both saturate to magnitude 2^(N-1)-1 on overflow.
  - -0 is accepted as input; a zero result is always +0.
  - Constants: 0.04 = 0x0000_0A3D, 5 = 0x0005_0000, 140 = 0x008C_0000.
- FSM, per neuron n (10 cycles):
  - FETCH: latch v[n], w[n], i_data, with i_addr = n.
  - MVV: t = v*v.
  - MK: t = 0.04*t.
  - M5: u = 5*v.
  - DV: dv = ((t + u) + 140) + (i - w).
  - MBV: t = b*v.
  - DW: dw = a*(t - w).
  - IV: vn = v + dt*dv.
  - IW: wn = w + dt*dw.
  - WB, spike test: if vn >= v_th (signed compare, inclusive), then v[n] = c, w[n] = wn + d, spikes[n] = 1. Otherwise v[n] = vn, w[n] = wn. Then n++.
- Timing:
  - step_start is sampled in IDLE: spikes cleared, n = 0, busy = 1 the next cycle.
  - busy stays high for exactly 10*NUM_NEURONS cycles.
  - The cycle after the last WB: busy = 0, step_done = 1, FSM in IDLE. A new step_start is accepted in that cycle.
- step_start while busy: ignored.
- wr_en:
  - Honoured only when not busy.
  - Ignored while busy and when coincident with an accepted step_start; the step wins.
- spikes hold their value until the next accepted step_start or reset.
- rd_v/rd_w mid-step: neurons < n show updated values; the others show old values.
- Index beyond NUM_NEURONS-1 on wr_addr/rd_addr: writes ignored, reads return 0.

Test Plan:
1. Reset, then step with a=0.02 (0x0000_051E), b=0.2 (0x0000_3333), c=-65, d=8, v_th=30, dt=0, i=0, M=4 -> busy high for exactly 40 cycles, step_done one pulse, all rd_v=0x8041_0000, rd_w=0x800D_0000, spikes=0.
2. M=1, rest state, dt=1.0, i=100.0 -> spike=1, rd_v=0x8041_0000, rd_w=0x8005_0000 (-5.0 exact).
3. M=4, dt=1, i[2]=100.0, others 0 -> spikes=4'b0100; i_addr steps 0,1,2,3 on FETCH cycles 0,10,20,30.
4. wr_en v=0x8000_0000 (-0), w=0, dt=0, i=0 -> after step rd_v=0x0000_0000, spikes=0. Repeat wr_en while busy -> no state change.
5. Assert reset at cycle 15 of a 40-cycle step -> next cycle busy=0, spikes=0, all states V_INIT/W_INIT, no step_done.
6. step_start held high 3 cycles -> exactly one step runs, one step_done. step_start in the step_done cycle -> back-to-back step, busy the next cycle.
